// File: rtl/eeg_soc_streamer_pkg.sv
// Shared types for the EEG sample streamer: ADC sample word and FSM state encodings.
package eeg_soc_streamer_pkg;

  typedef logic [15:0] AdcData_t;

  typedef logic [2:0] eeg_state_t;
  localparam eeg_state_t IDLE      = 3'd0;
  localparam eeg_state_t START     = 3'd1;
  localparam eeg_state_t STREAM    = 3'd2;
  localparam eeg_state_t EPOCH_END = 3'd3;
  localparam eeg_state_t WAIT_INF  = 3'd4;

endpackage

// File: rtl/eeg_sample_fifo.sv
// Sample buffer between the ADC and the CiM stream: DEPTH-entry FIFO, fall-through read data.
// Latency: written data is readable the cycle after the push edge. Backpressure: push ignored when full.
module eeg_sample_fifo
  import eeg_soc_streamer_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  AdcData_t                 push_dat,
  input  logic                     pop,
  output AdcData_t                 pop_dat,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int PTR_W = $clog2(DEPTH);

  AdcData_t         mem [DEPTH];
  logic [PTR_W:0]   wr_ptr;
  logic [PTR_W:0]   rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr[PTR_W-1:0]] <= push_dat;
  end

  assign pop_dat = mem[rd_ptr[PTR_W-1:0]];
  // Pointers carry one extra wrap bit, so the difference spans 0..DEPTH.
  assign level   = wr_ptr - rd_ptr;
  assign full    = level[PTR_W];
  assign empty   = (wr_ptr == rd_ptr);

endmodule

// File: rtl/eeg_soc_streamer.sv
// Streams buffered ADC samples to the CiM in epochs of SAMPLES_PER_EPOCH, then waits for inference.
// Latency: a pushed sample reaches soc_ctrl_eeg two edges later at best. Backpressure: adc_ready = !fifo_full (registered).
// Optional inference watchdog is built when EEG_STREAMER_TIMEOUT_EN is defined.
module eeg_soc_streamer
  import eeg_soc_streamer_pkg::*;
#(
  parameter int SAMPLES_PER_EPOCH = 3000,
  parameter int FIFO_DEPTH        = 8,
  parameter int SAMPLE_GAP        = 1
`ifdef EEG_STREAMER_TIMEOUT_EN
  , parameter int INF_TIMEOUT     = 65535
`endif
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     run,
  input  logic     adc_valid,
  input  AdcData_t adc_data,
  output logic     adc_ready,
  output logic     soc_ctrl_rst_n,
  output logic     soc_ctrl_start_eeg_load,
  output logic     soc_ctrl_new_eeg_data,
  output AdcData_t soc_ctrl_eeg,
  output logic     soc_ctrl_new_sleep_epoch,
  input  logic     soc_ctrl_inference_complete,
  output logic     epoch_done,
  output logic     timeout_err
);

  localparam int CNT_W = $clog2(SAMPLES_PER_EPOCH + 1);
  localparam int GAP_W = (SAMPLE_GAP > 1) ? $clog2(SAMPLE_GAP) : 1;
  localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

  eeg_state_t       state;
  logic [CNT_W-1:0] sample_cnt;
  logic [GAP_W-1:0] gap_cnt;
  logic             fifo_push;
  logic             fifo_pop;
  logic             last_pop;
  AdcData_t         fifo_dat;
  logic             fifo_full;
  logic             fifo_empty;
  logic [LVL_W-1:0] fifo_level;
  logic [LVL_W-1:0] level_next;
  logic             wd_expire;

  assign fifo_push  = adc_valid && adc_ready && !fifo_full;
  assign fifo_pop   = (state == STREAM) && !fifo_empty && (gap_cnt == '0);
  assign last_pop   = fifo_pop && (sample_cnt == CNT_W'(SAMPLES_PER_EPOCH - 1));
  assign level_next = fifo_level + LVL_W'(fifo_push) - LVL_W'(fifo_pop);

  assign soc_ctrl_start_eeg_load = (state == START);

  eeg_sample_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (fifo_push),
    .push_dat (adc_data),
    .pop      (fifo_pop),
    .pop_dat  (fifo_dat),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .level    (fifo_level)
  );

  // Ready looks one cycle ahead at occupancy so it never admits a push into a full buffer.
  always_ff @(posedge clk) begin
    if (rst) begin
      adc_ready      <= 1'b0;
      soc_ctrl_rst_n <= 1'b0;
    end else begin
      adc_ready      <= (level_next != LVL_W'(FIFO_DEPTH));
      soc_ctrl_rst_n <= 1'b1;
    end
  end

`ifdef EEG_STREAMER_TIMEOUT_EN
  localparam int WD_W = $clog2(INF_TIMEOUT + 1);
  logic [WD_W-1:0] wd_cnt;

  assign wd_expire = (state == WAIT_INF) && !soc_ctrl_inference_complete &&
                     (wd_cnt == WD_W'(INF_TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (rst || state != WAIT_INF) wd_cnt <= '0;
    else                          wd_cnt <= wd_cnt + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) timeout_err <= 1'b0;
    else     timeout_err <= timeout_err || wd_expire;
  end
`else
  assign wd_expire   = 1'b0;
  assign timeout_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state                    <= IDLE;
      sample_cnt               <= '0;
      gap_cnt                  <= '0;
      soc_ctrl_eeg             <= '0;
      soc_ctrl_new_eeg_data    <= 1'b0;
      soc_ctrl_new_sleep_epoch <= 1'b0;
      epoch_done               <= 1'b0;
    end else begin
      soc_ctrl_new_eeg_data    <= fifo_pop;
      soc_ctrl_new_sleep_epoch <= (state == EPOCH_END);
      epoch_done               <= 1'b0;
      if (fifo_pop) begin
        soc_ctrl_eeg <= fifo_dat;
        sample_cnt   <= sample_cnt + 1'b1;
        gap_cnt      <= GAP_W'(SAMPLE_GAP - 1);
      end else if (gap_cnt != '0) begin
        gap_cnt <= gap_cnt - 1'b1;
      end
      case (state)
        IDLE:      if (run) state <= START;
        START: begin
          sample_cnt <= '0;
          gap_cnt    <= '0;
          state      <= STREAM;
        end
        STREAM:    if (last_pop) state <= EPOCH_END;
        EPOCH_END: state <= WAIT_INF;
        WAIT_INF: begin
          if (soc_ctrl_inference_complete) begin
            epoch_done <= 1'b1;
            state      <= IDLE;
          end else if (wd_expire) begin
            state <= IDLE;
          end
        end
        default:   state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_eeg_soc_streamer.sv
// Scoreboard bench for eeg_soc_streamer: directed epochs, backpressure, mid-epoch reset, optional watchdog.
module tb_eeg_soc_streamer;
  import eeg_soc_streamer_pkg::*;

  localparam int SPE   = 4;
  localparam int DEPTH = 4;
  localparam int GAP   = 2;

  logic     clk = 1'b0;
  logic     rst = 1'b1;
  logic     run = 1'b0;
  logic     adc_valid = 1'b0;
  AdcData_t adc_data = '0;
  logic     adc_ready;
  logic     cim_rst_n;
  logic     start_pulse;
  logic     new_data;
  AdcData_t eeg;
  logic     sleep_pulse;
  logic     inf_cmp = 1'b0;
  logic     epoch_done;
  logic     timeout_err;

  int checks = 0;
  int passes = 0;
  int cyc = 0;
  int accepted = 0;
  int start_cnt = 0, sleep_cnt = 0, done_cnt = 0, strobe_cnt = 0;
  int sleep_cyc = -100, inf_cyc = -100, done_cyc = -100, start_cyc = -100;
  AdcData_t exp_q[$];
  int       strobe_cyc[$];
  AdcData_t last_eeg = '0;

  eeg_soc_streamer #(
    .SAMPLES_PER_EPOCH (SPE),
    .FIFO_DEPTH        (DEPTH),
    .SAMPLE_GAP        (GAP)
`ifdef EEG_STREAMER_TIMEOUT_EN
    , .INF_TIMEOUT     (16)
`endif
  ) dut (
    .clk                         (clk),
    .rst                         (rst),
    .run                         (run),
    .adc_valid                   (adc_valid),
    .adc_data                    (adc_data),
    .adc_ready                   (adc_ready),
    .soc_ctrl_rst_n              (cim_rst_n),
    .soc_ctrl_start_eeg_load     (start_pulse),
    .soc_ctrl_new_eeg_data       (new_data),
    .soc_ctrl_eeg                (eeg),
    .soc_ctrl_new_sleep_epoch    (sleep_pulse),
    .soc_ctrl_inference_complete (inf_cmp),
    .epoch_done                  (epoch_done),
    .timeout_err                 (timeout_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act === req) passes++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offers one word; must be called aligned just after a rising edge.
  task automatic push_word(input AdcData_t v);
    bit acc;
    int n;
    n = 0;
    adc_valid = 1'b1;
    adc_data  = v;
    do begin
      acc = adc_ready;
      tick();
      n++;
    end while (!acc && n < 200);
    if (acc) begin
      exp_q.push_back(v);
      accepted++;
    end
    check("push_accepted", acc, 1);
  endtask

  task automatic wait_sleep(input int n);
    int k;
    k = 0;
    while (sleep_cnt < n && k < 200) begin
      tick();
      k++;
    end
    check("sleep_epoch_count", sleep_cnt, n);
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_adc_ready"}, adc_ready, 0);
    check({tag, "_cim_rst_n"}, cim_rst_n, 0);
    check({tag, "_eeg"}, eeg, 0);
    check({tag, "_new_data"}, new_data, 0);
    check({tag, "_start"}, start_pulse, 0);
    check({tag, "_sleep"}, sleep_pulse, 0);
    check({tag, "_epoch_done"}, epoch_done, 0);
    check({tag, "_timeout_err"}, timeout_err, 0);
  endtask

  // Monitor: counts pulses and checks every strobe against the scoreboard.
  always @(negedge clk) begin
    bit exp_ok;
    if (start_pulse) begin start_cnt++; start_cyc = cyc; end
    if (sleep_pulse) begin sleep_cnt++; sleep_cyc = cyc; end
    if (epoch_done) begin
      done_cnt++;
      done_cyc = cyc;
      check("epoch_done_latency", cyc, inf_cyc + 1);
    end
    if (inf_cmp) inf_cyc = cyc;
    if (new_data) begin
      strobe_cnt++;
      strobe_cyc.push_back(cyc);
      exp_ok = (exp_q.size() != 0);
      check("strobe_pending", exp_ok, 1);
      if (exp_ok) check("eeg_value", eeg, exp_q.pop_front());
      last_eeg = eeg;
    end else if (!rst) begin
      check("eeg_hold", eeg, last_eeg);
    end
    if (rst) last_eeg = '0;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  initial begin
    AdcData_t vals1 [4] = '{16'h0011, 16'h0022, 16'h0033, 16'h0044};
    AdcData_t vals2 [5] = '{16'h0055, 16'h0066, 16'h0077, 16'h0088, 16'h0099};
    AdcData_t vals4 [4] = '{16'h1234, 16'h2345, 16'h3456, 16'h4567};
    bit found;

    rst = 1'b1;
    repeat (3) tick();
    check_reset("init");
    rst = 1'b0;
    tick();
    check("adc_ready_after_rst", adc_ready, 1);
    check("cim_rst_n_after_rst", cim_rst_n, 1);

    // Epoch 1: four samples, a stray inference_complete while streaming.
    run = 1'b1;
    foreach (vals1[i]) push_word(vals1[i]);
    adc_valid = 1'b0;
    inf_cmp = 1'b1;
    tick();
    inf_cmp = 1'b0;
    wait_sleep(1);
    check("epoch1_starts", start_cnt, 1);
    check("epoch1_strobes", strobe_cnt, 4);
    for (int i = 1; i < 4; i++) check("epoch1_strobe_spacing", strobe_cyc[i] - strobe_cyc[i-1], GAP);
    check("sleep_after_last_strobe", sleep_cyc > strobe_cyc[3], 1);
    check("stray_complete_ignored", done_cnt, 0);

    // Fill the buffer while waiting on inference; complete 7 cycles after the epoch pulse.
    fork
      begin
        foreach (vals2[i]) push_word(vals2[i]);
        adc_valid = 1'b0;
      end
      begin
        while (cyc < sleep_cyc + 6) tick();
        check("ready_low_when_full", adc_ready, 0);
        check("accepted_before_full", accepted, 8);
        while (cyc < sleep_cyc + 7) tick();
        inf_cmp = 1'b1;
        tick();
        inf_cmp = 1'b0;
      end
    join
    check("epoch1_done_count", done_cnt, 1);
    check("restart_after_done", start_cnt, 2);
    check("start_follows_done", start_cyc > done_cyc, 1);

    // Epoch 3: reset after its second strobe.
    wait_sleep(2);
    inf_cmp = 1'b1;
    tick();
    inf_cmp = 1'b0;
    push_word(16'h00AA);
    push_word(16'h00BB);
    push_word(16'h00CC);
    adc_valid = 1'b0;
    found = 1'b0;
    for (int k = 0; k < 50 && !found; k++) begin
      tick();
      if (new_data && eeg == 16'h00AA) found = 1'b1;
    end
    check("second_strobe_seen", found, 1);
    rst = 1'b1;
    run = 1'b0;
    tick();
    check_reset("mid_epoch");
    exp_q.delete();
    repeat (2) tick();
    check("no_sleep_on_reset", sleep_cnt, 2);
    rst = 1'b0;
    tick();
    check("adc_ready_after_rst2", adc_ready, 1);

    // Epoch 4: fresh samples only; stale buffered words would mismatch.
    run = 1'b1;
    foreach (vals4[i]) push_word(vals4[i]);
    adc_valid = 1'b0;
    wait_sleep(3);
    check("scoreboard_drained", exp_q.size(), 0);
    check("total_strobes", strobe_cnt, 14);
    check("total_starts", start_cnt, 4);

`ifdef EEG_STREAMER_TIMEOUT_EN
    run = 1'b0;
    while (cyc < sleep_cyc + 15) tick();
    check("timeout_not_yet", timeout_err, 0);
    tick();
    check("timeout_set", timeout_err, 1);
    repeat (3) tick();
    check("timeout_sticky", timeout_err, 1);
    check("no_done_on_timeout", done_cnt, 2);
    run = 1'b1;
    repeat (3) tick();
    check("idle_after_timeout", start_cnt, 5);
    run = 1'b0;
`else
    run = 1'b0;
    repeat (20) tick();
    check("timeout_tied_low", timeout_err, 0);
    check("wait_inf_holds", done_cnt, 2);
    inf_cmp = 1'b1;
    tick();
    inf_cmp = 1'b0;
    tick();
    check("final_done_count", done_cnt, 3);
`endif

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
